// File: rtl/a51_pkg.sv
// Shared definitions for the A5/1 step controller: state encodings, register
// geometry, default warm-up length and the majority helper.
package a51_pkg;

   typedef logic [2:0] state_t;

   localparam state_t IDLE   = 3'd0;
   localparam state_t LOAD   = 3'd1;
   localparam state_t WARMUP = 3'd2;
   localparam state_t RUN    = 3'd3;
   localparam state_t HOLD   = 3'd4;
   localparam state_t DONE   = 3'd5;

   localparam int X_LEN = 19;
   localparam int Y_LEN = 22;
   localparam int Z_LEN = 23;

   localparam int WARMUP_DEFAULT = 100;
   localparam int KS_W           = 8;

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/a51_step_ctrl_if.sv
// Keystream byte hand-off from the step controller to the image-XOR stage.
interface a51_step_ctrl_if
   import a51_pkg::*;
   ;
   logic [KS_W-1:0] ks_byte;
   logic            ks_valid;
   logic            ks_ready;

   modport master (output ks_byte, output ks_valid, input ks_ready);
   modport slave  (input ks_byte, input ks_valid, output ks_ready);
endinterface

// File: rtl/a51_majority.sv
// Majority-rule clock enables for the three A5/1 registers; all zero when
// step_en is low.
module a51_majority
   import a51_pkg::*;
(
   input  logic step_en,
   input  logic x_maj,
   input  logic y_maj,
   input  logic z_maj,
   output logic x_trigger,
   output logic y_trigger,
   output logic z_trigger
);

   logic maj;

   // A register steps when its tap agrees with the majority, so at least two step.
   assign maj       = maj3(x_maj, y_maj, z_maj);
   assign x_trigger = step_en & (x_maj == maj);
   assign y_trigger = step_en & (y_maj == maj);
   assign z_trigger = step_en & (z_maj == maj);

endmodule

// File: rtl/a51_step_ctrl.sv
// A5/1 step controller: load, warm-up, keystream byte packing with valid/ready.
// Optional A51_STEP_COUNT_EN adds a saturating 32-bit step_count output.
module a51_step_ctrl
   import a51_pkg::*;
#(
   parameter int WARMUP_CYCLES = WARMUP_DEFAULT,
   parameter int NUM_BYTES     = 16,
   parameter int CNT_W         = 16
)(
   input  logic clk,
   input  logic rst,
   input  logic start,
   input  logic x_maj,
   input  logic y_maj,
   input  logic z_maj,
   input  logic x_out,
   input  logic y_out,
   input  logic z_out,
   output logic load,
   output logic x_trigger,
   output logic y_trigger,
   output logic z_trigger,
   output logic busy,
   output logic done,
`ifdef A51_STEP_COUNT_EN
   output logic [31:0] step_count,
`endif
   a51_step_ctrl_if.master ks
);

   localparam logic [CNT_W-1:0] WARM_LAST   = CNT_W'(WARMUP_CYCLES - 1);
   localparam logic [CNT_W-1:0] BYTE_LAST   = CNT_W'(NUM_BYTES - 1);
   localparam bit               SKIP_WARMUP = (WARMUP_CYCLES == 0);

   state_t            state;
   logic              step_en;
   logic              ks_bit;
   logic [KS_W-2:0]   shift_q;
   logic [2:0]        bit_cnt;
   logic [CNT_W-1:0]  warm_cnt;
   logic [CNT_W-1:0]  byte_cnt;
   logic [KS_W-1:0]   ks_byte_q;
   logic              ks_valid_q;

   assign step_en = (state == WARMUP) || (state == RUN);
   assign ks_bit  = x_out ^ y_out ^ z_out;
   assign load    = (state == LOAD);
   assign done    = (state == DONE);
   assign busy    = (state != IDLE) && (state != DONE);

   assign ks.ks_byte  = ks_byte_q;
   assign ks.ks_valid = ks_valid_q;

   a51_majority u_majority (
      .step_en   (step_en),
      .x_maj     (x_maj),
      .y_maj     (y_maj),
      .z_maj     (z_maj),
      .x_trigger (x_trigger),
      .y_trigger (y_trigger),
      .z_trigger (z_trigger)
   );

   // Registers stay frozen in HOLD because step_en is low there.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         shift_q    <= '0;
         bit_cnt    <= '0;
         warm_cnt   <= '0;
         byte_cnt   <= '0;
         ks_byte_q  <= '0;
         ks_valid_q <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  state    <= LOAD;
                  shift_q  <= '0;
                  bit_cnt  <= '0;
                  warm_cnt <= '0;
                  byte_cnt <= '0;
               end
            end
            LOAD: begin
               state <= SKIP_WARMUP ? RUN : WARMUP;
            end
            WARMUP: begin
               warm_cnt <= warm_cnt + 1'b1;
               if (warm_cnt == WARM_LAST) begin
                  state <= RUN;
               end
            end
            RUN: begin
               shift_q <= {shift_q[KS_W-3:0], ks_bit};
               bit_cnt <= bit_cnt + 1'b1;
               if (bit_cnt == 3'd7) begin
                  ks_byte_q  <= {shift_q, ks_bit};
                  ks_valid_q <= 1'b1;
                  state      <= HOLD;
               end
            end
            HOLD: begin
               if (ks_valid_q && ks.ks_ready) begin
                  ks_valid_q <= 1'b0;
                  byte_cnt   <= byte_cnt + 1'b1;
                  state      <= (byte_cnt == BYTE_LAST) ? DONE : RUN;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

`ifdef A51_STEP_COUNT_EN
   logic        start_ok;
   logic [31:0] step_cnt_q;

   assign start_ok   = start && ((state == IDLE) || (state == DONE));
   assign step_count = step_cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         step_cnt_q <= '0;
      end else if (start_ok) begin
         step_cnt_q <= '0;
      end else if (step_en && (step_cnt_q != '1)) begin
         step_cnt_q <= step_cnt_q + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_a51_step_ctrl.sv
// Directed bench for a51_step_ctrl with WARMUP_CYCLES=100, NUM_BYTES=2.
// Keystream inputs are x_out=1, y_out=0, z_out=cycle parity, so bytes are AA then 55.
module tb_a51_step_ctrl;
   import a51_pkg::*;

   localparam int WARMUP = 100;
   localparam int NBYTES = 2;

   logic clk = 1'b0;
   logic rst, start;
   logic x_maj, y_maj, z_maj, x_out, y_out, z_out;
   logic load, x_trigger, y_trigger, z_trigger, busy, done;
`ifdef A51_STEP_COUNT_EN
   logic [31:0] step_count;
   logic [31:0] step_at_valid, step_at_done;
`endif

   a51_step_ctrl_if ks ();

   a51_step_ctrl #(
      .WARMUP_CYCLES (WARMUP),
      .NUM_BYTES     (NBYTES),
      .CNT_W         (16)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .x_maj      (x_maj),
      .y_maj      (y_maj),
      .z_maj      (z_maj),
      .x_out      (x_out),
      .y_out      (y_out),
      .z_out      (z_out),
      .load       (load),
      .x_trigger  (x_trigger),
      .y_trigger  (y_trigger),
      .z_trigger  (z_trigger),
      .busy       (busy),
      .done       (done),
`ifdef A51_STEP_COUNT_EN
      .step_count (step_count),
`endif
      .ks         (ks)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int passes = 0;
   int cyc;
   int first_load, load_count, first_valid, pulses, done_cyc;
   int hold_cycles, hold_bad;
   logic resume_ok, timed_out, aborted;
   logic [7:0] byte_log [2];
   logic [7:0] held_byte;

   // Hand-derived majority table indexed by {x_maj, y_maj, z_maj}.
   function automatic logic [2:0] expTrig(input logic [2:0] taps);
      case (taps)
         3'b000:  return 3'b111;
         3'b001:  return 3'b110;
         3'b010:  return 3'b101;
         3'b011:  return 3'b011;
         3'b100:  return 3'b011;
         3'b101:  return 3'b101;
         3'b110:  return 3'b110;
         default: return 3'b111;
      endcase
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected)
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      else
         passes++;
   endtask

   // One run from start; hold_len stretches the first HOLD, abort_cyc (>0) fires rst.
   task automatic applyStimulus(input int hold_len, input int abort_cyc, input bit poke_start);
      logic prev_valid;
      first_load = -1; load_count = 0; first_valid = -1; pulses = 0; done_cyc = -1;
      hold_cycles = 0; hold_bad = 0; resume_ok = 1'b0; timed_out = 1'b1; aborted = 1'b0;
      byte_log[0] = 8'h00; byte_log[1] = 8'h00; held_byte = 8'h00; prev_valid = 1'b0;
      @(negedge clk);
      start = 1'b1;
      ks.ks_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc = 1;
      for (int n = 0; n < 400; n++) begin
         {x_maj, y_maj, z_maj} = cyc[2:0];
         x_out = 1'b1;
         y_out = 1'b0;
         z_out = cyc[0];
         start = poke_start && (cyc == 20);
         ks.ks_ready = !(cyc >= 110 && cyc < 110 + hold_len);
         #1;
         if (cyc == abort_cyc) begin
            rst = 1'b1;
            #1;
            checkOutput("abort_valid", ks.ks_valid, 0);
            checkOutput("abort_busy", busy, 0);
            checkOutput("abort_trig", {x_trigger, y_trigger, z_trigger}, 0);
            checkOutput("abort_load", load, 0);
            #1 rst = 1'b0;
            aborted = 1'b1;
            timed_out = 1'b0;
            break;
         end
         if (load) begin
            load_count++;
            if (first_load < 0) first_load = cyc;
         end
         if (cyc == 1)
            checkOutput("load_trig", {x_trigger, y_trigger, z_trigger}, 0);
         if (cyc >= 2 && cyc <= 9)
            checkOutput($sformatf("warm_trig_c%0d", cyc), {x_trigger, y_trigger, z_trigger},
                        expTrig(cyc[2:0]));
         if (ks.ks_valid) begin
            hold_cycles++;
            if (!prev_valid) begin
               if (pulses < 2) byte_log[pulses] = ks.ks_byte;
               pulses++;
               held_byte = ks.ks_byte;
               if (first_valid < 0) begin
                  first_valid = cyc;
`ifdef A51_STEP_COUNT_EN
                  step_at_valid = step_count;
`endif
               end
            end
            if ({x_trigger, y_trigger, z_trigger} != 3'b000 || ks.ks_byte != held_byte)
               hold_bad++;
         end
         if (cyc == 110 + hold_len + 1)
            resume_ok = !ks.ks_valid && busy &&
                        ({x_trigger, y_trigger, z_trigger} == expTrig(cyc[2:0]));
         prev_valid = ks.ks_valid;
         if (done) begin
            done_cyc = cyc;
`ifdef A51_STEP_COUNT_EN
            step_at_done = step_count;
`endif
            timed_out = 1'b0;
            break;
         end
         @(negedge clk);
         cyc++;
      end
      start = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      start = 1'b0;
      {x_maj, y_maj, z_maj} = 3'b110;
      {x_out, y_out, z_out} = 3'b000;
      ks.ks_ready = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      checkOutput("rst_load", load, 0);
      checkOutput("rst_trig", {x_trigger, y_trigger, z_trigger}, 0);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_done", done, 0);
      checkOutput("rst_valid", ks.ks_valid, 0);
      checkOutput("rst_byte", ks.ks_byte, 0);
`ifdef A51_STEP_COUNT_EN
      checkOutput("rst_step_count", step_count, 0);
`endif
      rst = 1'b0;

      // Backpressured run with a stray start during warm-up.
      applyStimulus(20, 0, 1'b1);
      checkOutput("a_timeout", timed_out, 0);
      checkOutput("a_first_load", first_load, 1);
      checkOutput("a_load_count", load_count, 1);
      checkOutput("a_first_valid", first_valid, 110);
      checkOutput("a_byte0", byte_log[0], 8'hAA);
      checkOutput("a_byte1", byte_log[1], 8'h55);
      checkOutput("a_pulses", pulses, 2);
      checkOutput("a_hold_cycles", hold_cycles, 22);
      checkOutput("a_hold_bad", hold_bad, 0);
      checkOutput("a_resume", resume_ok, 1);
      checkOutput("a_done_cyc", done_cyc, 140);
`ifdef A51_STEP_COUNT_EN
      checkOutput("a_step_at_valid", step_at_valid, 108);
      checkOutput("a_step_at_done", step_at_done, 116);
`endif
      @(negedge clk);
      #1;
      checkOutput("a_done_hold", done, 1);
      checkOutput("a_done_busy", busy, 0);
      checkOutput("a_done_valid", ks.ks_valid, 0);

      // Reset in the middle of RUN.
      applyStimulus(0, 105, 1'b0);
      checkOutput("b_aborted", aborted, 1);
      @(negedge clk);
      #1;
      checkOutput("b_idle_busy", busy, 0);
      checkOutput("b_idle_done", done, 0);
      checkOutput("b_idle_byte", ks.ks_byte, 0);

      // Reset while a byte is held, then a clean run that must repeat the sequence.
      applyStimulus(20, 115, 1'b0);
      checkOutput("c_aborted", aborted, 1);
      applyStimulus(0, 0, 1'b0);
      checkOutput("d_timeout", timed_out, 0);
      checkOutput("d_load_count", load_count, 1);
      checkOutput("d_first_valid", first_valid, 110);
      checkOutput("d_byte0", byte_log[0], 8'hAA);
      checkOutput("d_byte1", byte_log[1], 8'h55);
      checkOutput("d_pulses", pulses, 2);
      checkOutput("d_hold_cycles", hold_cycles, 2);
      checkOutput("d_hold_bad", hold_bad, 0);
      checkOutput("d_resume", resume_ok, 1);
      checkOutput("d_done_cyc", done_cyc, 120);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
